// File: rtl/mips_pkg.sv
// Shared MIPS core constants: default address width, return-address stack depth,
// and the count-width helper used by the stack.
package mips_pkg;

  localparam int unsigned RA_AW    = 32;
  localparam int unsigned RA_DEPTH = 8;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned ra_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ra_stack_mem.sv
// DEPTH x AW register array: one synchronous write port, one combinational read port.
module ra_stack_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [AW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [AW-1:0]            rdata
);

  logic [AW-1:0] mem [DEPTH];

  // Contents need no reset: the reader masks them while the stack is empty.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ra_stack.sv
// Return-address stack for the jump-register path: JAL pushes PC+4, JR pops with zero-latency peek.
// Define RA_STACK_CHECK_EN to add jr_target comparison with a mispredict flag and saturating counter.
module ra_stack
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = RA_DEPTH,
  parameter int unsigned AW    = RA_AW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_en,
  input  logic [AW-1:0]                 push_addr,
  input  logic                          pop_en,
`ifdef RA_STACK_CHECK_EN
  input  logic [AW-1:0]                 jr_target,
  output logic                          mispredict,
  output logic [15:0]                   mispred_cnt,
`endif
  output logic [AW-1:0]                 top_addr,
  output logic                          top_valid,
  output logic [ra_cnt_w(DEPTH)-1:0]    count,
  output logic                          full,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = ra_cnt_w(DEPTH);

  logic [PW-1:0] top_ptr, ptr_nxt, wr_ptr;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          empty_c, full_c, we_c, ovf_set_c, unf_set_c;
  logic [AW-1:0] rd_data;

  assign empty_c = (cnt_q == '0);
  assign full_c  = (cnt_q == CW'(DEPTH));

  // Next pointer/count and write-port control for each push/pop combination.
  always_comb begin
    ptr_nxt   = top_ptr;
    cnt_nxt   = cnt_q;
    wr_ptr    = top_ptr + PW'(1);
    we_c      = 1'b0;
    ovf_set_c = 1'b0;
    unf_set_c = 1'b0;
    case ({push_en, pop_en})
      2'b10: begin
        we_c    = 1'b1;
        ptr_nxt = top_ptr + PW'(1);
        if (full_c) ovf_set_c = 1'b1;
        else        cnt_nxt   = cnt_q + CW'(1);
      end
      2'b01: begin
        if (empty_c) begin
          unf_set_c = 1'b1;
        end else begin
          ptr_nxt = top_ptr - PW'(1);
          cnt_nxt = cnt_q - CW'(1);
        end
      end
      2'b11: begin
        we_c = 1'b1;
        if (empty_c) begin
          ptr_nxt = top_ptr + PW'(1);
          cnt_nxt = CW'(1);
        end else begin
          wr_ptr = top_ptr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_ptr   <= '0;
      cnt_q     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      top_ptr   <= ptr_nxt;
      cnt_q     <= cnt_nxt;
      overflow  <= overflow  | ovf_set_c;
      underflow <= underflow | unf_set_c;
    end
  end

  ra_stack_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we_c),
    .waddr (wr_ptr),
    .wdata (push_addr),
    .raddr (top_ptr),
    .rdata (rd_data)
  );

  assign top_valid = !empty_c;
  assign top_addr  = empty_c ? '0 : rd_data;
  assign count     = cnt_q;
  assign full      = full_c;

`ifdef RA_STACK_CHECK_EN
  assign mispredict = pop_en && top_valid && (top_addr != jr_target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  mispred_cnt <= '0;
    else if (mispredict && mispred_cnt != '1)    mispred_cnt <= mispred_cnt + 16'(1);
  end
`endif

endmodule

// File: tb/tb_ra_stack.sv
// Scoreboard bench for ra_stack: a queue-based reference stack predicts every cycle's outputs.
module tb_ra_stack;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 32;

  logic          clk, rst_n, push_en, pop_en;
  logic [AW-1:0] push_addr, top_addr;
  logic          top_valid, full, overflow, underflow;
  logic [3:0]    count;
`ifdef RA_STACK_CHECK_EN
  logic [AW-1:0] jr_target;
  logic          mispredict;
  logic [15:0]   mispred_cnt;
`endif

  ra_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_en   (push_en),
    .push_addr (push_addr),
    .pop_en    (pop_en),
`ifdef RA_STACK_CHECK_EN
    .jr_target   (jr_target),
    .mispredict  (mispredict),
    .mispred_cnt (mispred_cnt),
`endif
    .top_addr  (top_addr),
    .top_valid (top_valid),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] top;
    logic        tv;
    logic [3:0]  cnt;
    logic        full;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mq[$];
  logic        m_ovf, m_unf;
  int          n_tests, n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare the DUT's current outputs with the oldest scoreboard entry.
  task automatic sample();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("top_addr",  top_addr,         e.top);
    chk("top_valid", 32'(top_valid),   32'(e.tv));
    chk("count",     32'(count),       32'(e.cnt));
    chk("full",      32'(full),        32'(e.full));
    chk("overflow",  32'(overflow),    32'(e.ovf));
    chk("underflow", 32'(underflow),   32'(e.unf));
  endtask

  // Drive one cycle of stimulus, check pre-edge outputs, then advance the reference stack.
  task automatic step(input logic pu, input logic [31:0] a, input logic po, output logic [31:0] obs_top);
    exp_t e;
    @(negedge clk);
    push_en   = pu;
    push_addr = a;
    pop_en    = po;
    e.top  = (mq.size() > 0) ? mq[$] : 32'd0;
    e.tv   = (mq.size() > 0);
    e.cnt  = 4'(mq.size());
    e.full = (mq.size() == DEPTH);
    e.ovf  = m_ovf;
    e.unf  = m_unf;
    sb.push_back(e);
    #1;
    obs_top = top_addr;
    sample();
    if (pu && po) begin
      if (mq.size() > 0) mq[mq.size()-1] = a;
      else               mq.push_back(a);
    end else if (pu) begin
      if (mq.size() == DEPTH) begin
        void'(mq.pop_front());
        m_ovf = 1'b1;
      end
      mq.push_back(a);
    end else if (po) begin
      if (mq.size() > 0) void'(mq.pop_back());
      else               m_unf = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] t;
    n_tests = 0;
    n_fail  = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    rst_n     = 1'b0;
    push_en   = 1'b0;
    pop_en    = 1'b0;
    push_addr = '0;
`ifdef RA_STACK_CHECK_EN
    jr_target = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset then idle
    step(1'b0, 32'd0, 1'b0, t);
    chk("rst_top", t, 32'd0);

    // Three pushes, three pops, LIFO order visible in the pop cycles
    step(1'b1, 32'h0040_0010, 1'b0, t);
    step(1'b1, 32'h0040_0020, 1'b0, t);
    step(1'b1, 32'h0040_0030, 1'b0, t);
    step(1'b0, 32'd0, 1'b1, t); chk("pop3_a", t, 32'h0040_0030);
    step(1'b0, 32'd0, 1'b1, t); chk("pop3_b", t, 32'h0040_0020);
    step(1'b0, 32'd0, 1'b1, t); chk("pop3_c", t, 32'h0040_0010);
    step(1'b0, 32'd0, 1'b0, t);
    chk("pop3_empty_valid", 32'(top_valid), 32'd0);

    // Fill past capacity: entry 1 is lost
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 32'(i), 1'b0, t);
      if (i == 9) chk("full_before_9th", 32'(full), 32'd1);
    end
    step(1'b0, 32'd0, 1'b0, t);
    chk("ovf_after_9th", 32'(overflow), 32'd1);
    chk("cnt_after_9th", 32'(count), 32'd8);
    for (int i = 9; i >= 2; i--) begin
      step(1'b0, 32'd0, 1'b1, t);
      chk("drain_top", t, 32'(i));
    end

    // Underflow on empty pop, then recovery with a push
    step(1'b0, 32'd0, 1'b1, t);
    chk("unf_pop_top", t, 32'd0);
    step(1'b1, 32'h100, 1'b0, t);
    chk("unf_flag", 32'(underflow), 32'd1);
    step(1'b1, 32'h200, 1'b0, t);
    chk("after_unf_top", t, 32'h100);

    // Simultaneous push and pop replaces the top entry
    step(1'b1, 32'h300, 1'b1, t);
    chk("pp_same_cycle", t, 32'h200);
    step(1'b0, 32'd0, 1'b0, t);
    chk("pp_next_top", t, 32'h300);
    chk("pp_cnt", 32'(count), 32'd2);

    // Push+pop on an empty stack acts as a plain push
    step(1'b0, 32'd0, 1'b1, t);
    step(1'b0, 32'd0, 1'b1, t);
    step(1'b1, 32'h444, 1'b1, t);
    chk("pp_empty_top", t, 32'd0);

    // Grow to five entries, then assert reset asynchronously between edges
    for (int i = 0; i < 4; i++) step(1'b1, 32'h1000 + 32'(i), 1'b0, t);
    step(1'b0, 32'd0, 1'b0, t);
    chk("pre_rst_cnt", 32'(count), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_cnt",   32'(count),     32'd0);
    chk("async_rst_valid", 32'(top_valid), 32'd0);
    chk("async_rst_top",   top_addr,       32'd0);
    chk("async_rst_ovf",   32'(overflow),  32'd0);
    chk("async_rst_unf",   32'(underflow), 32'd0);
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'd0, 1'b0, t);

`ifdef RA_STACK_CHECK_EN
    step(1'b1, 32'h500, 1'b0, t);
    step(1'b1, 32'h600, 1'b0, t);
    jr_target = 32'h600;
    step(1'b0, 32'd0, 1'b1, t);
    chk("match_mispredict", 32'(mispredict), 32'd0);
    jr_target = 32'h504;
    step(1'b0, 32'd0, 1'b1, t);
    chk("mispredict", 32'(mispredict), 32'd1);
    chk("mispred_cnt_0", 32'(mispred_cnt), 32'd0);
    jr_target = 32'h0;
    step(1'b0, 32'd0, 1'b0, t);
    chk("mispred_cnt_1", 32'(mispred_cnt), 32'd1);
`endif

    // Random mix, including back-to-back pushes and pops
    for (int i = 0; i < 300; i++) begin
      logic [1:0] r;
      r = 2'($urandom_range(0, 3));
      step(r[1], $urandom, r[0], t);
    end
    step(1'b0, 32'd0, 1'b0, t);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ra_stack.md
Name: ra_stack

Overview:
- Return-address stack for the MIPS single-cycle core; the writer side of the jump-register path.
- JAL pushes the link address (PC+4) on the clock edge. JR pops the top entry in the same cycle it is decoded.
- The popped entry is the predicted JR target, used alongside the reg[rs] target.
- Sits in the fetch/next-PC logic next to the JR decode.

Parameters:
- DEPTH, 8, number of stack entries (power of two, >=2)
- AW, 32, address width in bits

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- push_en  input  1  JAL retiring this cycle
- push_addr  input  AW  link address (PC+4) to push
- pop_en  input  1  JR retiring this cycle (driven by the JR decode)
- top_addr  output  AW  current top-of-stack, combinational peek, 0 when empty
- top_valid  output  1  stack non-empty
- count  output  $clog2(DEPTH)+1  entries held
- full  output  1  count==DEPTH
- overflow  output  1  sticky: push while full occurred
- underflow  output  1  sticky: pop while empty occurred

Behaviour:
- Reset (rst_n low, async): count=0, top pointer=0, overflow=0, underflow=0. Entry contents are don't-care but read as 0 through top_addr. Reset asserted mid-operation discards all entries immediately.
- Storage: circular buffer of DEPTH entries, top pointer wraps modulo DEPTH.
- Read is combinational: top_addr = entry[top] when count>0, else 0. The core consumes the value in the same cycle as pop_en, so there is zero-cycle read latency.
- All updates take effect at the next rising clk edge (1-cycle write latency).
- push only:
  - not full: pointer+1, write push_addr, count+1.
  - full: pointer+1 (wraps), overwrite the oldest entry, count stays DEPTH, overflow<=1.
- pop only:
  - count>0: pointer-1, count-1.
  - empty: no state change, underflow<=1, top_addr remains 0.
- push and pop same cycle (JR-then-JAL equivalent):
  - pointer and count unchanged, entry[top] replaced by push_addr.
  - If empty: behaves as a push only, count becomes 1, no underflow flagged.
- Neither asserted: hold.
- Sticky flags clear only on reset.
- No other sequencing constraints. pop_en and push_en may assert every cycle.

Optional Feature:
- Macro: RA_STACK_CHECK_EN.
- With it defined:
  - Extra input jr_target (AW bits, the reg[rs] value).
  - Extra outputs mispredict (1) and mispred_cnt (16).
  - On pop_en with top_valid, mispredict is combinationally high when top_addr != jr_target.
  - mispred_cnt increments on the clock edge, saturates at 16'hFFFF, and resets to 0.
- Without it: those ports and the logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package (mips_pkg): AW default, RA_DEPTH default, count-width function/constant.
- One natural sub-module: ra_stack_mem, the DEPTH x AW register array with one write port and one combinational read port.
- Pointer, count and flag logic stay in ra_stack.

Test Plan:
- Reset then idle: top_valid=0, top_addr=0, count=0, full=0, overflow=underflow=0.
- Push 0x00400010, 0x00400020, 0x00400030, then pop x3: top_addr reads 0x00400030, 0x00400020, 0x00400010 in the pop cycles; count ends 0 and top_valid=0.
- DEPTH=8, push values 1..9: full=1 after the 8th, overflow=1 after the 9th, count=8. Popping 8 times returns 9,8,7,6,5,4,3,2 (entry 1 lost).
- Pop when empty: underflow=1, count stays 0, top_addr=0. A following push of 0x100 gives top_addr=0x100 and count=1.
- With count=2 (top 0x200), assert push_en+pop_en with push_addr=0x300: top_addr=0x200 that cycle, then 0x300; count stays 2.
- Assert rst_n low mid-sequence with count=5: outputs return to reset values asynchronously, before the next clk edge.
- RA_STACK_CHECK_EN: top=0x500 and pop with jr_target=0x504 gives mispredict=1 and mispred_cnt 0->1. A pop with a matching target leaves the count unchanged.
